// File: rtl/memory_stage.sv
// ---------------------------------------------------------------------------
// memory_stage
//
// Memory-access stage of the five-stage pipeline. Takes the EX/MEM register
// outputs (m_*), runs load/store transactions on the data-memory bus with a
// req/ack handshake, steers byte lanes in both directions, flags misaligned
// word accesses, and holds the EX/MEM register through m_stall while a bus
// access is outstanding. Ends in the MEM/WB pipeline register (w_*).
//
// Ports
//   clock, reset       : single clock, synchronous active-high reset
//   m_dst_reg          : destination register index from EX/MEM
//   m_mem_read         : instruction is a load
//   m_mem_write        : instruction is a store
//   m_mem_byte         : byte access (0 = word access)
//   m_reg_write        : instruction writes the register file
//   m_mem_to_reg       : writeback source, 1 = load data, 0 = ALU result
//   m_mem_write_data   : store data
//   m_alu_result       : effective address, or ALU result for writeback
//   w_stall            : writeback stage is stalled
//   m_stall            : hold the EX/MEM register
//   dmem_req/we/addr/wdata/be : data-memory request side
//   dmem_ack, dmem_rdata      : data-memory response (rdata valid with ack)
//   w_dst_reg, w_reg_write, w_write_data, w_fault : MEM/WB register outputs
// ---------------------------------------------------------------------------
module memory_stage (
    input  logic        clock,
    input  logic        reset,

    input  logic [4:0]  m_dst_reg,
    input  logic        m_mem_read,
    input  logic        m_mem_write,
    input  logic        m_mem_byte,
    input  logic        m_reg_write,
    input  logic        m_mem_to_reg,
    input  logic [31:0] m_mem_write_data,
    input  logic [31:0] m_alu_result,
    input  logic        w_stall,
    output logic        m_stall,

    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,

    output logic [4:0]  w_dst_reg,
    output logic        w_reg_write,
    output logic [31:0] w_write_data,
    output logic        w_fault
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] load_buf_q;

    logic [4:0]  w_dst_reg_q;
    logic        w_reg_write_q;
    logic [31:0] w_write_data_q;
    logic        w_fault_q;

    logic [4:0]  w_dst_reg_d;
    logic        w_reg_write_d;
    logic [31:0] w_write_data_d;
    logic        w_fault_d;

    logic        access;
    logic        misaligned;
    logic        start;
    logic [3:0]  be_raw;
    logic [31:0] load_data;
    logic [31:0] result;

    // -----------------------------------------------------------------------
    // Instruction classification
    // -----------------------------------------------------------------------
    assign access     = m_mem_read | m_mem_write;
    // Byte accesses can never be misaligned; only word accesses are checked.
    assign misaligned = access & ~m_mem_byte & (m_alu_result[1:0] != 2'b00);
    assign start      = access & ~misaligned;

    // Stall covers the IDLE cycle that launches an access and every cycle
    // spent waiting for the ack. DONE is the completion cycle and only
    // stalls when writeback itself is stalled.
    assign m_stall = w_stall
                   | ((state_q == IDLE) & start)
                   | (state_q == ACCESS);

    // -----------------------------------------------------------------------
    // Bus request side (combinational from state and the held m_* inputs)
    // -----------------------------------------------------------------------
    assign dmem_req  = (state_q == ACCESS);
    assign dmem_we   = dmem_req & m_mem_write;
    assign dmem_addr = {m_alu_result[31:2], 2'b00};

    always_comb begin
        if (m_mem_byte) begin
            be_raw     = 4'b0001 << m_alu_result[1:0];
            // Replicate the byte on every lane; byte enables pick the one used.
            dmem_wdata = {4{m_mem_write_data[7:0]}};
        end else begin
            be_raw     = 4'b1111;
            dmem_wdata = m_mem_write_data;
        end
    end

    // Byte enables are suppressed whenever no request is on the bus so an
    // idle bus never shows a partial write strobe.
    assign dmem_be = dmem_req ? be_raw : 4'b0000;

    // -----------------------------------------------------------------------
    // Load steering (little-endian lane select, zero-extended)
    // -----------------------------------------------------------------------
    always_comb begin
        load_data = dmem_rdata;
        if (m_mem_byte) begin
            case (m_alu_result[1:0])
                2'd0:    load_data = {24'd0, dmem_rdata[7:0]};
                2'd1:    load_data = {24'd0, dmem_rdata[15:8]};
                2'd2:    load_data = {24'd0, dmem_rdata[23:16]};
                default: load_data = {24'd0, dmem_rdata[31:24]};
            endcase
        end
    end

    // Writeback data source. In DONE the buffered load data is presented;
    // for a misaligned load the buffer still holds an older value, but the
    // register write is suppressed so it is never committed.
    assign result = m_mem_to_reg ? load_buf_q : m_alu_result;

    // -----------------------------------------------------------------------
    // Access FSM and load buffer
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            load_buf_q <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Acks seen here belong to no request and are ignored.
                    if (start) begin
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (dmem_ack) begin
                        state_q    <= DONE;
                        load_buf_q <= load_data;
                    end
                end
                DONE: begin
                    // Parked here while writeback is stalled; the buffer is
                    // held and the bus is not re-issued.
                    if (!w_stall) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // MEM/WB register next state
    // -----------------------------------------------------------------------
    always_comb begin
        if (m_stall) begin
            // Bubble: the instruction in MEM has not completed yet.
            w_dst_reg_d    = 5'd0;
            w_reg_write_d  = 1'b0;
            w_write_data_d = 32'd0;
            w_fault_d      = 1'b0;
        end else begin
            w_dst_reg_d    = m_dst_reg;
            w_reg_write_d  = m_reg_write & ~misaligned;
            w_write_data_d = result;
            w_fault_d      = misaligned;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            w_dst_reg_q    <= 5'd0;
            w_reg_write_q  <= 1'b0;
            w_write_data_q <= 32'd0;
            w_fault_q      <= 1'b0;
        end else if (!w_stall) begin
            w_dst_reg_q    <= w_dst_reg_d;
            w_reg_write_q  <= w_reg_write_d;
            w_write_data_q <= w_write_data_d;
            w_fault_q      <= w_fault_d;
        end
    end

    assign w_dst_reg    = w_dst_reg_q;
    assign w_reg_write  = w_reg_write_q;
    assign w_write_data = w_write_data_q;
    assign w_fault      = w_fault_q;

endmodule

// File: tb/tb_memory_stage.sv
// ---------------------------------------------------------------------------
// tb_memory_stage
//
// Self-checking bench for memory_stage. A table of single-instruction
// vectors is driven through the stage with a bus responder that acks after
// k request cycles; expected writeback records go into a scoreboard queue
// when an instruction is driven and are popped when it retires. Hand-written
// sequences cover reset, writeback stall around an access, and reset in the
// middle of an access.
// ---------------------------------------------------------------------------
module tb_memory_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  m_dst_reg;
    logic        m_mem_read;
    logic        m_mem_write;
    logic        m_mem_byte;
    logic        m_reg_write;
    logic        m_mem_to_reg;
    logic [31:0] m_mem_write_data;
    logic [31:0] m_alu_result;
    logic        w_stall;
    logic        m_stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [4:0]  w_dst_reg;
    logic        w_reg_write;
    logic [31:0] w_write_data;
    logic        w_fault;

    always #5 clock = ~clock;

    memory_stage dut (
        .clock            (clock),
        .reset            (reset),
        .m_dst_reg        (m_dst_reg),
        .m_mem_read       (m_mem_read),
        .m_mem_write      (m_mem_write),
        .m_mem_byte       (m_mem_byte),
        .m_reg_write      (m_reg_write),
        .m_mem_to_reg     (m_mem_to_reg),
        .m_mem_write_data (m_mem_write_data),
        .m_alu_result     (m_alu_result),
        .w_stall          (w_stall),
        .m_stall          (m_stall),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_be          (dmem_be),
        .dmem_ack         (dmem_ack),
        .dmem_rdata       (dmem_rdata),
        .w_dst_reg        (w_dst_reg),
        .w_reg_write      (w_reg_write),
        .w_write_data     (w_write_data),
        .w_fault          (w_fault)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic        byt;
        logic        rw;
        logic        m2r;
        logic [4:0]  dst;
        logic [31:0] wd;
        logic [31:0] alu;
        logic [31:0] rdata;
        int          k;
        int          e_req;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_addr;
        int          e_stall;
        logic        e_rw;
        logic [4:0]  e_dst;
        logic [31:0] e_data;
        logic        e_fault;
    } vec_t;

    typedef struct {
        logic        rw;
        logic [4:0]  dst;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_m(input logic rd, input logic wr, input logic byt, input logic rw,
                           input logic m2r, input logic [4:0] dst, input logic [31:0] wd,
                           input logic [31:0] alu);
        m_mem_read       = rd;
        m_mem_write      = wr;
        m_mem_byte       = byt;
        m_reg_write      = rw;
        m_mem_to_reg     = m2r;
        m_dst_reg        = dst;
        m_mem_write_data = wd;
        m_alu_result     = alu;
    endtask

    task automatic push_exp(input logic rw, input logic [4:0] dst, input logic [31:0] data,
                            input logic fault);
        exp_t e;
        e.rw    = rw;
        e.dst   = dst;
        e.data  = data;
        e.fault = fault;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL %s_sb_empty: got 0 entries expected 1", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_w_reg_write"},  32'(w_reg_write),  32'(e.rw));
            chk({tag, "_w_dst_reg"},    32'(w_dst_reg),    32'(e.dst));
            chk({tag, "_w_write_data"}, w_write_data,      e.data);
            chk({tag, "_w_fault"},      32'(w_fault),      32'(e.fault));
        end
    endtask

    // Run one instruction through MEM with a bus that acks on the k-th
    // request cycle; checks the bus side while it runs and the writeback
    // record once it retires.
    task automatic run_vec(input vec_t v, input string tag);
        int stall_cnt;
        int req_cnt;
        bit done;
        stall_cnt = 0;
        req_cnt   = 0;
        done      = 1'b0;
        @(negedge clock);
        drive_m(v.rd, v.wr, v.byt, v.rw, v.m2r, v.dst, v.wd, v.alu);
        dmem_rdata = v.rdata;
        dmem_ack   = 1'b0;
        push_exp(v.e_rw, v.e_dst, v.e_data, v.e_fault);
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            #1;
            if (dmem_req) begin
                req_cnt++;
                chk({tag, "_addr"},  dmem_addr,        v.e_addr);
                chk({tag, "_be"},    32'(dmem_be),     32'(v.e_be));
                chk({tag, "_we"},    32'(dmem_we),     32'(v.wr));
                chk({tag, "_wdata"}, dmem_wdata,       v.e_wdata);
                dmem_ack = (req_cnt == v.k);
            end else begin
                dmem_ack = 1'b0;
                chk({tag, "_idle_we_be"}, 32'({dmem_we, dmem_be}), 32'd0);
            end
            if (m_stall) begin
                stall_cnt++;
                @(negedge clock);
            end else begin
                done = 1'b1;
            end
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got m_stall stuck high expected release within 40 cycles", tag);
        end
        @(posedge clock);
        #1;
        dmem_ack = 1'b0;
        pop_cmp(tag);
        chk({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(v.e_stall));
        chk({tag, "_req_cycles"},   32'(req_cnt),   32'(v.e_req));
    endtask

    vec_t vecs[12];
    vec_t post;
    int   req_seen;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            rd wr by rw m2 dst  wd            alu            rdata          k  req be       e_wdata        e_addr         stl rw dst  data           flt
        vecs[0]  = '{1, 0, 0, 1, 1, 5,  32'h12345678, 32'h00000100, 32'hDEADBEEF, 3, 3, 4'b1111, 32'h12345678, 32'h00000100, 4, 1, 5,  32'hDEADBEEF, 0};
        vecs[1]  = '{1, 0, 1, 1, 1, 7,  32'h00000000, 32'h00000103, 32'h80112233, 2, 2, 4'b1000, 32'h00000000, 32'h00000100, 3, 1, 7,  32'h00000080, 0};
        vecs[2]  = '{0, 1, 1, 0, 0, 0,  32'h000000A5, 32'h00000102, 32'h00000000, 1, 1, 4'b0100, 32'hA5A5A5A5, 32'h00000100, 2, 0, 0,  32'h00000102, 0};
        vecs[3]  = '{0, 1, 0, 1, 0, 3,  32'h00000077, 32'h00000101, 32'h00000000, 1, 0, 4'b0000, 32'h00000000, 32'h00000000, 0, 0, 3,  32'h00000101, 1};
        vecs[4]  = '{0, 0, 0, 1, 0, 9,  32'h00000000, 32'hCAFEF00D, 32'h00000000, 1, 0, 4'b0000, 32'h00000000, 32'h00000000, 0, 1, 9,  32'hCAFEF00D, 0};
        vecs[5]  = '{1, 0, 1, 1, 1, 10, 32'hFFFFFF5A, 32'h00000101, 32'h11223344, 1, 1, 4'b0010, 32'h5A5A5A5A, 32'h00000100, 2, 1, 10, 32'h00000033, 0};
        vecs[6]  = '{1, 0, 1, 1, 1, 11, 32'h00000000, 32'h00000100, 32'hFFFFFF7E, 1, 1, 4'b0001, 32'h00000000, 32'h00000100, 2, 1, 11, 32'h0000007E, 0};
        // Misaligned load: write suppressed, data is the stale load buffer.
        vecs[7]  = '{1, 0, 0, 1, 1, 4,  32'h00000000, 32'h00000202, 32'hFFFFFFFF, 1, 0, 4'b0000, 32'h00000000, 32'h00000000, 0, 0, 4,  32'h0000007E, 1};
        vecs[8]  = '{0, 1, 0, 0, 0, 0,  32'h0BADF00D, 32'h00000204, 32'h00000000, 2, 2, 4'b1111, 32'h0BADF00D, 32'h00000204, 3, 0, 0,  32'h00000204, 0};
        vecs[9]  = '{1, 0, 0, 1, 1, 12, 32'h00000000, 32'hFFFFFFFC, 32'h01020304, 4, 4, 4'b1111, 32'h00000000, 32'hFFFFFFFC, 5, 1, 12, 32'h01020304, 0};
        vecs[10] = '{1, 0, 1, 1, 0, 13, 32'h00000000, 32'h00000102, 32'hAABBCCDD, 1, 1, 4'b0100, 32'h00000000, 32'h00000100, 2, 1, 13, 32'h00000102, 0};
        // Non-memory op with unaligned ALU result: no fault.
        vecs[11] = '{0, 0, 0, 1, 0, 14, 32'h00000000, 32'h00000003, 32'h00000000, 1, 0, 4'b0000, 32'h00000000, 32'h00000000, 0, 1, 14, 32'h00000003, 0};
        post     = '{1, 0, 0, 1, 1, 23, 32'h00000000, 32'h00000300, 32'h13572468, 2, 2, 4'b1111, 32'h00000000, 32'h00000300, 3, 1, 23, 32'h13572468, 0};

        // Reset state
        reset      = 1'b1;
        w_stall    = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        drive_m(0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        chk("rst_w_dst_reg",    32'(w_dst_reg),    32'd0);
        chk("rst_w_reg_write",  32'(w_reg_write),  32'd0);
        chk("rst_w_write_data", w_write_data,      32'd0);
        chk("rst_w_fault",      32'(w_fault),      32'd0);
        chk("rst_req_we_be",    32'({dmem_req, dmem_we, dmem_be}), 32'd0);
        chk("rst_m_stall_lo",   32'(m_stall),      32'd0);
        w_stall = 1'b1;
        #1;
        chk("rst_m_stall_hi",   32'(m_stall),      32'd1);
        @(negedge clock);
        w_stall = 1'b0;
        reset   = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Writeback stall held across an access and 3 cycles past the ack
        @(negedge clock);
        drive_m(0, 0, 0, 1, 0, 5'd9, 32'd0, 32'h12345678);
        push_exp(1, 5'd9, 32'h12345678, 0);
        #1;
        chk("ws_nop_m_stall", 32'(m_stall), 32'd0);
        @(posedge clock);
        #1;
        pop_cmp("ws_nop");
        @(negedge clock);
        drive_m(1, 0, 0, 1, 1, 5'd6, 32'd0, 32'h00000040);
        dmem_rdata = 32'h55AA55AA;
        w_stall    = 1'b1;
        push_exp(1, 5'd6, 32'h55AA55AA, 0);
        req_seen = 0;
        for (int t = 0; t < 6; t++) begin
            if (t != 0) @(negedge clock);
            #1;
            if (dmem_req) req_seen++;
            dmem_ack = dmem_req && (req_seen == 2);
            chk($sformatf("ws_m_stall_t%0d", t),   32'(m_stall),   32'd1);
            chk($sformatf("ws_hold_dst_t%0d", t),  32'(w_dst_reg), 32'd9);
            chk($sformatf("ws_hold_data_t%0d", t), w_write_data,   32'h12345678);
        end
        @(negedge clock);
        w_stall  = 1'b0;
        dmem_ack = 1'b0;
        #1;
        chk("ws_release_m_stall", 32'(m_stall),  32'd0);
        chk("ws_release_req",     32'(dmem_req), 32'd0);
        @(posedge clock);
        #1;
        pop_cmp("ws_load");
        chk("ws_req_cycles", 32'(req_seen), 32'd2);

        // Reset in the second ACCESS cycle, with writeback stalled so the
        // MEM/WB register is holding a non-zero record when reset hits.
        @(negedge clock);
        drive_m(0, 0, 0, 1, 0, 5'd21, 32'd0, 32'h0000600D);
        push_exp(1, 5'd21, 32'h0000600D, 0);
        @(posedge clock);
        #1;
        pop_cmp("mr_nop");
        @(negedge clock);
        drive_m(1, 0, 0, 1, 1, 5'd22, 32'd0, 32'h00000080);
        dmem_rdata = 32'hFFFFFFFF;
        w_stall    = 1'b1;
        #1;
        chk("mr_idle_stall", 32'(m_stall),  32'd1);
        chk("mr_idle_req",   32'(dmem_req), 32'd0);
        @(negedge clock);
        #1;
        chk("mr_access1_req", 32'(dmem_req), 32'd1);
        @(negedge clock);
        #1;
        chk("mr_access2_req", 32'(dmem_req),  32'd1);
        chk("mr_hold_dst",    32'(w_dst_reg), 32'd21);
        reset = 1'b1;
        drive_m(0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
        @(posedge clock);
        #1;
        chk("mr_req_dropped",   32'(dmem_req),     32'd0);
        chk("mr_w_dst_reg",     32'(w_dst_reg),    32'd0);
        chk("mr_w_reg_write",   32'(w_reg_write),  32'd0);
        chk("mr_w_write_data",  w_write_data,      32'd0);
        chk("mr_w_fault",       32'(w_fault),      32'd0);
        chk("mr_m_stall_eq_ws", 32'(m_stall),      32'd1);
        @(negedge clock);
        reset   = 1'b0;
        w_stall = 1'b0;
        #1;
        chk("mr_post_m_stall", 32'(m_stall), 32'd0);
        @(negedge clock);
        dmem_ack = 1'b1;
        #1;
        chk("mr_stray_ack_req", 32'(dmem_req), 32'd0);
        @(posedge clock);
        #1;
        dmem_ack = 1'b0;
        chk("mr_after_ack_req",   32'(dmem_req), 32'd0);
        chk("mr_after_ack_stall", 32'(m_stall),  32'd0);
        run_vec(post, "mr_post_load");

        @(negedge clock);
        drive_m(0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
        @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
